// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters with snapshot shadows and a 1-deep registered read port.
// Build option: define PERF_SATURATE_EN to saturate counters on carry-out instead of wrapping.
module perf_counter_bank #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned INC_W  = 3,
  localparam int unsigned ADDR_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    count_en,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*INC_W-1:0] inc,
  input  logic                    clear,
  input  logic                    snap,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_resp,
  output logic [CNT_W-1:0]        rd_data,
  output logic                    rd_err,
  output logic [NUM_CH-1:0]       ovf
);

  logic [CNT_W-1:0]  live     [NUM_CH];
  logic [CNT_W-1:0]  live_nxt [NUM_CH];
  logic [CNT_W-1:0]  shadow   [NUM_CH];
  logic [CNT_W:0]    inc_ext  [NUM_CH];
  logic [CNT_W:0]    sum      [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] ovf_nxt;
  logic              addr_ok;

  // Per-channel next state; clear overrides any increment in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      inc_ext[i]  = (CNT_W+1)'(inc[i*INC_W +: INC_W]);
      sum[i]      = {1'b0, live[i]} + inc_ext[i];
      hit[i]      = count_en & ch_mask[i];
      live_nxt[i] = live[i];
      ovf_nxt[i]  = ovf[i];
      if (clear) begin
        live_nxt[i] = '0;
        ovf_nxt[i]  = 1'b0;
      end else if (hit[i]) begin
        ovf_nxt[i] = ovf[i] | sum[i][CNT_W];
`ifdef PERF_SATURATE_EN
        live_nxt[i] = sum[i][CNT_W] ? '1 : sum[i][CNT_W-1:0];
`else
        live_nxt[i] = sum[i][CNT_W-1:0];
`endif
      end
    end
  end

  // Shadow captures the pre-edge live value, so snap+clear keeps the old counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        live[i] <= live_nxt[i];
        if (snap) begin
          shadow[i] <= live[i];
        end
      end
      ovf <= ovf_nxt;
    end
  end

  always_comb begin
    addr_ok = (32'(rd_addr) < NUM_CH);
  end

  // Read pipeline samples the shadow before any same-edge snap update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_resp <= 1'b0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      rd_resp <= rd_req;
      rd_err  <= rd_req & ~addr_ok;
      if (rd_req) begin
        rd_data <= addr_ok ? shadow[rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed and randomized checks of perf_counter_bank against an arithmetic model.
// The model honours PERF_SATURATE_EN the same way as the design build.
module tb_perf_counter_bank;
  localparam int unsigned NUM_CH = 12;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned INC_W  = 3;
  localparam int unsigned ADDR_W = $clog2(NUM_CH);
  localparam int          MAXV   = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    count_en;
  logic [NUM_CH-1:0]       ch_mask;
  logic [NUM_CH*INC_W-1:0] inc;
  logic                    clear;
  logic                    snap;
  logic                    rd_req;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    rd_resp;
  logic [CNT_W-1:0]        rd_data;
  logic                    rd_err;
  logic [NUM_CH-1:0]       ovf;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .INC_W(INC_W)) dut (
    .clk(clk), .rst(rst), .count_en(count_en), .ch_mask(ch_mask), .inc(inc),
    .clear(clear), .snap(snap), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_resp(rd_resp), .rd_data(rd_data), .rd_err(rd_err), .ovf(ovf)
  );

  int tests  = 0;
  int errors = 0;

  int                m_live   [NUM_CH];
  int                m_shadow [NUM_CH];
  logic [NUM_CH-1:0] m_ovf;
  logic              exp_resp;
  logic              exp_err;
  logic [CNT_W-1:0]  exp_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_live[i]   = 0;
      m_shadow[i] = 0;
    end
    m_ovf    = '0;
    exp_resp = 1'b0;
    exp_err  = 1'b0;
    exp_data = '0;
  endtask

  // One rising edge of the reference behaviour, using the inputs as driven.
  task automatic model_edge();
    exp_resp = rd_req;
    if (rd_req) begin
      if (int'(rd_addr) >= NUM_CH) begin
        exp_data = '0;
        exp_err  = 1'b1;
      end else begin
        exp_data = CNT_W'(m_shadow[rd_addr]);
        exp_err  = 1'b0;
      end
    end else begin
      exp_err = 1'b0;
    end
    if (snap) m_shadow = m_live;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clear) begin
        m_live[i] = 0;
        m_ovf[i]  = 1'b0;
      end else if (count_en && ch_mask[i]) begin
        int s;
        s = m_live[i] + int'(inc[i*INC_W +: INC_W]);
        if (s > MAXV) begin
          m_ovf[i] = 1'b1;
`ifdef PERF_SATURATE_EN
          m_live[i] = MAXV;
`else
          m_live[i] = s % (MAXV + 1);
`endif
        end else begin
          m_live[i] = s;
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rd_resp"}, 64'(rd_resp), 64'd0);
    check({tag, ".rd_data"}, 64'(rd_data), 64'd0);
    check({tag, ".rd_err"},  64'(rd_err),  64'd0);
    check({tag, ".ovf"},     64'(ovf),     64'd0);
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check("rd_resp", 64'(rd_resp), 64'(exp_resp));
    check("rd_err",  64'(rd_err),  64'(exp_err));
    check("rd_data", 64'(rd_data), 64'(exp_data));
    check("ovf",     64'(ovf),     64'(m_ovf));
    @(negedge clk);
  endtask

  task automatic set_inc(input int ch, input int v);
    inc[ch*INC_W +: INC_W] = INC_W'(v);
  endtask

  task automatic run_count(input int n);
    count_en = 1'b1;
    repeat (n) cycle();
    count_en = 1'b0;
    inc      = '0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    cycle();
    snap = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic read_ch(input int addr, input logic [63:0] exp_v, input string tag);
    rd_req  = 1'b1;
    rd_addr = ADDR_W'(addr);
    cycle();
    rd_req  = 1'b0;
    check({tag, ".resp"}, 64'(rd_resp), 64'd1);
    check({tag, ".data"}, 64'(rd_data), exp_v);
  endtask

  initial begin
    rst = 1'b0; count_en = 1'b0; ch_mask = '0; inc = '0;
    clear = 1'b0; snap = 1'b0; rd_req = 1'b0; rd_addr = '0;
    model_reset();
    #1;
    check_zero("por");
    cycle();
    rst = 1'b1;

    // Overflow ch0 and leave a response on the port, then reset asynchronously with a read pending.
    ch_mask = '1;
    set_inc(0, 7);
    run_count(40);
    check("pre.ovf0", 64'(ovf[0]), 64'd1);
    do_snap();
`ifdef PERF_SATURATE_EN
    read_ch(0, 64'd255, "pre.rd0");
`else
    read_ch(0, 64'd24, "pre.rd0");
`endif
    rd_req  = 1'b1;
    rd_addr = '0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_zero("async_rst");
    rd_req = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;

    // Ten single increments on ch0.
    ch_mask = '1;
    set_inc(0, 1);
    run_count(10);
    do_snap();
    read_ch(0, 64'd10, "t1.rd0");
    check("t1.err", 64'(rd_err), 64'd0);

    // Only ch1 enabled; back-to-back reads.
    do_clear();
    ch_mask = 12'h002;
    set_inc(0, 3);
    set_inc(1, 3);
    run_count(5);
    do_snap();
    rd_req  = 1'b1;
    rd_addr = 4'd0;
    cycle();
    check("t2.rd0", 64'(rd_data), 64'd0);
    check("t2.resp0", 64'(rd_resp), 64'd1);
    rd_addr = 4'd1;
    cycle();
    check("t2.rd1", 64'(rd_data), 64'd15);
    check("t2.resp1", 64'(rd_resp), 64'd1);
    rd_req = 1'b0;
    cycle();
    check("t2.idle", 64'(rd_resp), 64'd0);

    // ch2 preloaded to 250, then +7 overflows.
    do_clear();
    ch_mask = 12'h004;
    set_inc(2, 5);
    run_count(50);
    check("t3.ovf_pre", 64'(ovf[2]), 64'd0);
    set_inc(2, 7);
    run_count(1);
    check("t3.ovf", 64'(ovf[2]), 64'd1);
    do_snap();
`ifdef PERF_SATURATE_EN
    read_ch(2, 64'd255, "t3.rd2");
`else
    read_ch(2, 64'd1, "t3.rd2");
`endif
    do_clear();
    check("t3.ovf_clr", 64'(ovf[2]), 64'd0);

    // clear + snap + increment together at live=40.
    ch_mask = '1;
    set_inc(0, 5);
    run_count(8);
    clear = 1'b1; snap = 1'b1; count_en = 1'b1; set_inc(0, 5);
    cycle();
    clear = 1'b0; snap = 1'b0; count_en = 1'b0; inc = '0;
    read_ch(0, 64'd40, "t4.shadow");
    do_snap();
    read_ch(0, 64'd0, "t4.live");

    // Out-of-range and last valid address.
    read_ch(13, 64'd0, "t5.rd13");
    check("t5.err13", 64'(rd_err), 64'd1);
    read_ch(11, 64'd0, "t5.rd11");
    check("t5.err11", 64'(rd_err), 64'd0);

    // Read in the same cycle as snap returns the old shadow.
    do_clear();
    ch_mask = '1;
    set_inc(3, 7);
    run_count(1);
    do_snap();
    set_inc(3, 2);
    run_count(1);
    rd_req = 1'b1; rd_addr = 4'd3; snap = 1'b1;
    cycle();
    rd_req = 1'b0; snap = 1'b0;
    check("t6.old", 64'(rd_data), 64'd7);
    read_ch(3, 64'd9, "t6.new");

    // Randomized traffic with one mid-run asynchronous reset.
    for (int k = 0; k < 600; k++) begin
      count_en = ($urandom_range(0, 3) != 0);
      ch_mask  = NUM_CH'($urandom);
      inc      = (NUM_CH*INC_W)'({$urandom, $urandom});
      clear    = ($urandom_range(0, 31) == 0);
      snap     = ($urandom_range(0, 7) == 0);
      rd_req   = $urandom_range(0, 1) == 1;
      rd_addr  = ADDR_W'($urandom_range(0, 15));
      if (k == 300) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_zero("rand_rst");
        cycle();
        rst = 1'b1;
      end else begin
        cycle();
      end
    end

    count_en = 1'b0; clear = 1'b0; rd_req = 1'b0;
    do_snap();
    for (int i = 0; i < NUM_CH; i++) begin
      read_ch(i, 64'(m_live[i]), "final");
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
